// File: rtl/mpr121_poller.sv
// mpr121_poller: brings up an MPR121 over an i2c_master AXI-stream front end, then polls its touch status.
// Optional MPR121_THRESH_CFG_EN: program 12 touch/release threshold pairs between settle and ECR.
module mpr121_poller #(
    parameter logic [6:0]  I2C_ADDR      = 7'h5A,
    parameter int unsigned POLL_TICKS    = 27_000,
    parameter int unsigned SETTLE_TICKS  = 27_000,
    parameter int unsigned TIMEOUT_TICKS = 270_000,
    parameter int unsigned REINIT_TICKS  = 270_000_000
) (
    input  logic        clk_27M,
    input  logic        reset,
    output logic [6:0]  cmd_address,
    output logic        cmd_start,
    output logic        cmd_read,
    output logic        cmd_write,
    output logic        cmd_write_m,
    output logic        cmd_stop,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        tx_tlast,
    input  logic [7:0]  rx_tdata,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    output logic [11:0] touch,
    output logic        touch_valid,
    output logic        init_done,
    output logic        error
);

    typedef enum logic [4:0] {
        RST_CMD, RST_REG, RST_VAL, SETTLE,
`ifdef MPR121_THRESH_CFG_EN
        TH_CMD, TH_REG, TH_DATA,
`endif
        ECR_CMD, ECR_REG, ECR_VAL, POLL_WAIT,
        PTR_CMD, PTR_DATA, RD0_CMD, RD0_B, RD1_CMD, RD1_B
    } state_t;

    state_t      state, state_next;
    logic [31:0] tcnt;
    logic [31:0] rcnt;
    logic [7:0]  b0;
    logic        timeout;
    logic        reinit_due;
    logic        tx_fire;
    logic        rx_fire;
`ifdef MPR121_THRESH_CFG_EN
    logic [4:0]  th_idx;
`endif

    assign cmd_address = I2C_ADDR;
    assign reinit_due  = (rcnt >= REINIT_TICKS);
    assign timeout     = (state != SETTLE) && (state != POLL_WAIT) && (tcnt == TIMEOUT_TICKS);
    assign tx_fire     = tx_tvalid && tx_tready;
    assign rx_fire     = rx_tvalid && rx_tready;

    always_comb begin
        state_next  = state;
        cmd_start   = 1'b0;
        cmd_read    = 1'b0;
        cmd_write   = 1'b0;
        cmd_write_m = 1'b0;
        cmd_stop    = 1'b0;
        cmd_valid   = 1'b0;
        tx_tdata    = '0;
        tx_tvalid   = 1'b0;
        tx_tlast    = 1'b0;
        rx_tready   = 1'b0;
        case (state)
            RST_CMD, ECR_CMD: begin
                cmd_valid   = 1'b1;
                cmd_write_m = 1'b1;
                cmd_start   = 1'b1;
                cmd_stop    = 1'b1;
                if (cmd_ready) state_next = (state == RST_CMD) ? RST_REG : ECR_REG;
            end
            RST_REG: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h80;
                if (tx_tready) state_next = RST_VAL;
            end
            RST_VAL: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h63;
                tx_tlast  = 1'b1;
                if (tx_tready) state_next = SETTLE;
            end
            SETTLE: begin
`ifdef MPR121_THRESH_CFG_EN
                if (tcnt >= SETTLE_TICKS) state_next = TH_CMD;
`else
                if (tcnt >= SETTLE_TICKS) state_next = ECR_CMD;
`endif
            end
`ifdef MPR121_THRESH_CFG_EN
            TH_CMD: begin
                cmd_valid   = 1'b1;
                cmd_write_m = 1'b1;
                cmd_start   = 1'b1;
                cmd_stop    = 1'b1;
                if (cmd_ready) state_next = TH_REG;
            end
            TH_REG: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h41;
                if (tx_tready) state_next = TH_DATA;
            end
            TH_DATA: begin
                // even index = touch threshold, odd index = release threshold
                tx_tvalid = 1'b1;
                tx_tdata  = th_idx[0] ? 8'd6 : 8'd12;
                tx_tlast  = (th_idx == 5'd23);
                if (tx_tready && th_idx == 5'd23) state_next = ECR_CMD;
            end
`endif
            ECR_REG: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h5E;
                if (tx_tready) state_next = ECR_VAL;
            end
            ECR_VAL: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h8C;
                tx_tlast  = 1'b1;
                if (tx_tready) state_next = POLL_WAIT;
            end
            POLL_WAIT: begin
                if (tcnt >= POLL_TICKS) state_next = PTR_CMD;
            end
            PTR_CMD: begin
                cmd_valid = 1'b1;
                cmd_write = 1'b1;
                cmd_start = 1'b1;
                if (cmd_ready) state_next = PTR_DATA;
            end
            PTR_DATA: begin
                tx_tvalid = 1'b1;
                tx_tdata  = 8'h00;
                tx_tlast  = 1'b1;
                if (tx_tready) state_next = RD0_CMD;
            end
            RD0_CMD: begin
                cmd_valid = 1'b1;
                cmd_read  = 1'b1;
                cmd_start = 1'b1;
                if (cmd_ready) state_next = RD0_B;
            end
            RD0_B: begin
                rx_tready = 1'b1;
                if (rx_tvalid) state_next = RD1_CMD;
            end
            RD1_CMD: begin
                cmd_valid = 1'b1;
                cmd_read  = 1'b1;
                cmd_stop  = 1'b1;
                if (cmd_ready) state_next = RD1_B;
            end
            RD1_B: begin
                rx_tready = 1'b1;
                if (rx_tvalid) state_next = (rx_tdata[7] || reinit_due) ? RST_CMD : POLL_WAIT;
            end
            default: state_next = RST_CMD;
        endcase
        // A timed-out handshake spends one cycle with everything deasserted before re-init.
        if (timeout || reset) begin
            cmd_start   = 1'b0;
            cmd_read    = 1'b0;
            cmd_write   = 1'b0;
            cmd_write_m = 1'b0;
            cmd_stop    = 1'b0;
            cmd_valid   = 1'b0;
            tx_tdata    = '0;
            tx_tvalid   = 1'b0;
            tx_tlast    = 1'b0;
            rx_tready   = 1'b0;
        end
        if (timeout) state_next = RST_CMD;
    end

    always_ff @(posedge clk_27M) begin
        if (reset) begin
            state       <= RST_CMD;
            tcnt        <= '0;
            rcnt        <= '0;
            b0          <= '0;
            touch       <= '0;
            touch_valid <= 1'b0;
            init_done   <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            touch_valid <= 1'b0;
            if (state_next != state || timeout) tcnt <= '0;
            else if (tcnt != '1)                tcnt <= tcnt + 32'd1;
            if (state == ECR_VAL && tx_fire) begin
                rcnt      <= '0;
                init_done <= 1'b1;
            end else if (rcnt != '1) begin
                rcnt <= rcnt + 32'd1;
            end
            if (timeout) begin
                error     <= 1'b1;
                init_done <= 1'b0;
            end
            if (state == RD0_B && rx_fire) b0 <= rx_tdata;
            if (state == RD1_B && rx_fire) begin
                if (rx_tdata[7]) begin
                    error     <= 1'b1;
                    init_done <= 1'b0;
                end else begin
                    touch       <= {rx_tdata[3:0], b0};
                    touch_valid <= 1'b1;
                    error       <= 1'b0;
                    if (reinit_due) init_done <= 1'b0;
                end
            end
        end
    end

`ifdef MPR121_THRESH_CFG_EN
    always_ff @(posedge clk_27M) begin
        if (reset || state != TH_DATA) th_idx <= '0;
        else if (tx_fire)               th_idx <= th_idx + 5'd1;
    end
`endif

endmodule

// File: tb/tb_mpr121_poller.sv
// Directed bench for mpr121_poller with an i2c_master BFM (ready after 3 cycles, rx bytes after reads).
`timescale 1ns/1ps
module tb_mpr121_poller;

    localparam int unsigned SETTLE = 200;
    localparam int unsigned POLL   = 100;
    localparam int unsigned TMO    = 300;
    localparam int unsigned REINIT = 2500;
    localparam logic [4:0]  F_WM   = 5'b10011;   // {write_m, write, read, start, stop}
    localparam logic [4:0]  F_PTR  = 5'b01010;
    localparam logic [4:0]  F_RD0  = 5'b00110;
    localparam logic [4:0]  F_RD1  = 5'b00101;

    logic        clk_27M = 1'b0;
    logic        reset;
    logic [6:0]  cmd_address;
    logic        cmd_start, cmd_read, cmd_write, cmd_write_m, cmd_stop, cmd_valid, cmd_ready;
    logic [7:0]  tx_tdata;
    logic        tx_tvalid, tx_tready, tx_tlast;
    logic [7:0]  rx_tdata;
    logic        rx_tvalid, rx_tready;
    logic [11:0] touch;
    logic        touch_valid, init_done, error;

    typedef struct {
        logic        is_cmd;
        logic [4:0]  flags;
        logic [7:0]  data;
        logic        last;
        int unsigned cyc;
    } beat_t;

    beat_t       beat_q[$];
    int unsigned tv_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic        hold_cmd;
    logic [7:0]  rx_b0, rx_b1, rx_d;
    int          cw, tw;

    mpr121_poller #(
        .I2C_ADDR      (7'h5A),
        .POLL_TICKS    (POLL),
        .SETTLE_TICKS  (SETTLE),
        .TIMEOUT_TICKS (TMO),
        .REINIT_TICKS  (REINIT)
    ) dut (
        .clk_27M     (clk_27M),
        .reset       (reset),
        .cmd_address (cmd_address),
        .cmd_start   (cmd_start),
        .cmd_read    (cmd_read),
        .cmd_write   (cmd_write),
        .cmd_write_m (cmd_write_m),
        .cmd_stop    (cmd_stop),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .tx_tdata    (tx_tdata),
        .tx_tvalid   (tx_tvalid),
        .tx_tready   (tx_tready),
        .tx_tlast    (tx_tlast),
        .rx_tdata    (rx_tdata),
        .rx_tvalid   (rx_tvalid),
        .rx_tready   (rx_tready),
        .touch       (touch),
        .touch_valid (touch_valid),
        .init_done   (init_done),
        .error       (error)
    );

    always #5 clk_27M = ~clk_27M;

    always @(posedge clk_27M) cyc <= cyc + 1;

    // cyc at the logging negedge = index of the posedge before the transfer edge
    always @(negedge clk_27M) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready)
                beat_q.push_back('{is_cmd: 1'b1,
                                   flags: {cmd_write_m, cmd_write, cmd_read, cmd_start, cmd_stop},
                                   data: 8'h00, last: 1'b0, cyc: cyc});
            if (tx_tvalid && tx_tready)
                beat_q.push_back('{is_cmd: 1'b0, flags: 5'd0, data: tx_tdata, last: tx_tlast, cyc: cyc});
            if (touch_valid) tv_q.push_back(cyc);
        end
    end

    initial begin
        cmd_ready = 1'b0;
        tx_tready = 1'b0;
        cw = 0;
        tw = 0;
        forever begin
            @(posedge clk_27M);
            #1;
            if (reset || hold_cmd || cmd_ready || !cmd_valid) begin
                cmd_ready = 1'b0;
                cw = 0;
            end else begin
                cw++;
                if (cw >= 3) cmd_ready = 1'b1;
            end
            if (reset || tx_tready || !tx_tvalid) begin
                tx_tready = 1'b0;
                tw = 0;
            end else begin
                tw++;
                if (tw >= 3) tx_tready = 1'b1;
            end
        end
    end

    initial begin
        rx_tvalid = 1'b0;
        rx_tdata  = 8'h00;
        forever begin
            @(negedge clk_27M);
            if (!reset && cmd_valid && cmd_ready && cmd_read) begin
                rx_d = cmd_stop ? rx_b1 : rx_b0;
                repeat (5) @(posedge clk_27M);
                #1;
                rx_tdata  = rx_d;
                rx_tvalid = 1'b1;
                for (int i = 0; i < 1000; i++) begin
                    @(negedge clk_27M);
                    if (rx_tready || reset) break;
                end
                @(posedge clk_27M);
                #1;
                rx_tvalid = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=bench completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_beat(input string tag, output beat_t b);
        int unsigned n = 0;
        while (beat_q.size() == 0 && n < 3000) begin
            @(posedge clk_27M);
            n++;
        end
        if (beat_q.size() != 0) begin
            b = beat_q.pop_front();
        end else begin
            b = '{is_cmd: 1'b0, flags: 5'd0, data: 8'd0, last: 1'b0, cyc: 0};
            chk({tag, "_wait"}, 32'(beat_q.size()), 32'd1);
        end
    endtask

    task automatic expect_cmd(input string tag, input logic [4:0] flags, output int unsigned c);
        beat_t b;
        pop_beat(tag, b);
        chk(tag, 32'({b.is_cmd, b.flags}), 32'({1'b1, flags}));
        c = b.cyc;
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] data, input logic last,
                             output int unsigned c);
        beat_t b;
        pop_beat(tag, b);
        chk(tag, 32'({b.is_cmd, b.data, b.last}), 32'({1'b0, data, last}));
        c = b.cyc;
    endtask

    task automatic expect_init(input bit first_done, output int unsigned a);
        int unsigned c, c63;
        if (!first_done) expect_cmd("init_rst_cmd", F_WM, c);
        expect_tx("init_rst_reg", 8'h80, 1'b0, c);
        expect_tx("init_rst_val", 8'h63, 1'b1, c63);
`ifdef MPR121_THRESH_CFG_EN
        expect_cmd("init_th_cmd", F_WM, c);
        chk("settle_gap", 32'(c - c63 >= SETTLE), 32'd1);
        expect_tx("init_th_reg", 8'h41, 1'b0, c);
        for (int i = 0; i < 24; i++)
            expect_tx("init_th_data", (i % 2 == 1) ? 8'd6 : 8'd12, (i == 23), c);
        expect_cmd("init_ecr_cmd", F_WM, c);
`else
        expect_cmd("init_ecr_cmd", F_WM, c);
        chk("settle_gap", 32'(c - c63 >= SETTLE), 32'd1);
`endif
        expect_tx("init_ecr_reg", 8'h5E, 1'b0, c);
        expect_tx("init_ecr_val", 8'h8C, 1'b1, a);
        @(negedge clk_27M);
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    task automatic expect_poll(input logic [7:0] b0, input logic [7:0] b1,
                               output int unsigned pc, output int unsigned tv);
        int unsigned c;
        int unsigned n = 0;
        rx_b0 = b0;
        rx_b1 = b1;
        tv = 0;
        expect_cmd("poll_ptr_cmd", F_PTR, pc);
        expect_tx("poll_ptr_data", 8'h00, 1'b1, c);
        expect_cmd("poll_rd0_cmd", F_RD0, c);
        expect_cmd("poll_rd1_cmd", F_RD1, c);
        if (!b1[7]) begin
            while (tv_q.size() == 0 && n < 200) begin
                @(posedge clk_27M);
                n++;
            end
            if (tv_q.size() == 0) chk("poll_strobe_wait", 32'(tv_q.size()), 32'd1);
            else tv = tv_q.pop_front();
            @(negedge clk_27M);
        end
    endtask

    initial begin
        int unsigned a, pc, tv, c;
        int unsigned n;
        bit done;
        reset    = 1'b1;
        hold_cmd = 1'b0;
        rx_b0    = 8'h00;
        rx_b1    = 8'h00;
        repeat (3) @(posedge clk_27M);
        @(negedge clk_27M);
        chk("rst_cmd_valid",   32'(cmd_valid),   32'd0);
        chk("rst_tx_tvalid",   32'(tx_tvalid),   32'd0);
        chk("rst_rx_tready",   32'(rx_tready),   32'd0);
        chk("rst_cmd_address", 32'(cmd_address), 32'h5A);
        chk("rst_touch",       32'(touch),       32'd0);
        chk("rst_touch_valid", 32'(touch_valid), 32'd0);
        chk("rst_init_done",   32'(init_done),   32'd0);
        chk("rst_error",       32'(error),       32'd0);
        reset = 1'b0;

        expect_init(1'b0, a);

        expect_poll(8'h05, 8'h0A, pc, tv);
        chk("poll1_touch", 32'(touch), 32'hA05);
        chk("poll1_error", 32'(error), 32'd0);
        chk("poll1_strobe_width", 32'(touch_valid), 32'd0);
        @(negedge clk_27M);
        chk("poll1_strobe_count", 32'(tv_q.size()), 32'd0);

        // stall the next pointer-write command until the handshake times out
        hold_cmd = 1'b1;
        n = 0;
        while (!cmd_valid && n < 1000) begin
            @(negedge clk_27M);
            n++;
        end
        chk("to_ptr_cmd_seen", 32'({cmd_valid, cmd_write, cmd_write_m}), 32'b110);
        n = 0;
        while (cmd_valid && n < 1000) begin
            @(negedge clk_27M);
            n++;
        end
        chk("to_elapsed", n, TMO);
        chk("to_cmd_valid_drop", 32'(cmd_valid), 32'd0);
        @(negedge clk_27M);
        chk("to_error", 32'(error), 32'd1);
        chk("to_init_done", 32'(init_done), 32'd0);
        chk("to_reinit_cmd", 32'({cmd_valid, cmd_write_m}), 32'b11);
        hold_cmd = 1'b0;
        expect_init(1'b0, a);

        expect_poll(8'h3C, 8'h07, pc, tv);
        chk("poll2_touch", 32'(touch), 32'h73C);
        chk("poll2_error_cleared", 32'(error), 32'd0);
        expect_poll(8'h3C, 8'h07, pc, c);
        chk("poll_gap", 32'(pc - tv >= POLL), 32'd1);
        chk("poll3_touch", 32'(touch), 32'h73C);

        expect_poll(8'h3C, 8'h80, pc, tv);
        expect_cmd("ovcf_rst_cmd", F_WM, c);
        @(negedge clk_27M);
        chk("ovcf_error", 32'(error), 32'd1);
        chk("ovcf_init_done", 32'(init_done), 32'd0);
        chk("ovcf_touch_held", 32'(touch), 32'h73C);
        chk("ovcf_no_strobe", 32'(tv_q.size()), 32'd0);
        expect_init(1'b1, a);

        // RD1 accept edge is tv; counter there is (tv - 1) - (a + 1) edges past the ECR accept
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            expect_poll(8'h3C, 8'h07, pc, tv);
            chk("reinit_poll_touch", 32'(touch), 32'h73C);
            if (tv - a - 2 >= REINIT) begin
                expect_cmd("reinit_rst_cmd", F_WM, c);
                @(negedge clk_27M);
                chk("reinit_init_done", 32'(init_done), 32'd0);
                chk("reinit_touch_held", 32'(touch), 32'h73C);
                done = 1'b1;
            end
        end
        chk("reinit_seen", 32'(done), 32'd1);

        expect_tx("fin_rst_reg", 8'h80, 1'b0, c);
        expect_tx("fin_rst_val", 8'h63, 1'b1, c);
`ifdef MPR121_THRESH_CFG_EN
        expect_cmd("fin_th_cmd", F_WM, c);
        expect_tx("fin_th_reg", 8'h41, 1'b0, c);
        for (int i = 0; i < 9; i++)
            expect_tx("fin_th_data", (i % 2 == 1) ? 8'd6 : 8'd12, 1'b0, c);
`else
        expect_cmd("fin_ecr_cmd", F_WM, c);
`endif
        @(negedge clk_27M);
        reset = 1'b1;
        @(negedge clk_27M);
        chk("mid_rst_cmd_valid",   32'(cmd_valid),   32'd0);
        chk("mid_rst_tx_tvalid",   32'(tx_tvalid),   32'd0);
        chk("mid_rst_rx_tready",   32'(rx_tready),   32'd0);
        chk("mid_rst_touch",       32'(touch),       32'd0);
        chk("mid_rst_touch_valid", 32'(touch_valid), 32'd0);
        chk("mid_rst_init_done",   32'(init_done),   32'd0);
        chk("mid_rst_error",       32'(error),       32'd0);
        beat_q.delete();
        tv_q.delete();
        reset = 1'b0;
        expect_cmd("post_rst_cmd", F_WM, c);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
